clock_display_mux: RTL and testbench
====================================

# clock_display_mux

Time-multiplexed seven-segment driver that sits directly downstream of the HH:MM:SS digit counter chain and consumes its six BCD digit values. It snapshots all six digits once per display frame, so a frame never mixes values from before and after a ripple carry. It scans the digits across an 8-digit, common-anode display with inter-digit ghost blanking, and blinks the HH.MM.SS separators from a one-second pulse.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot; legal range 2 to 2^20.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- clk  input  1  system clock; every register samples on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sec_pulse  input  1  one-cycle-high strobe once per second; toggles the separator phase.
- display_en  input  1  when low, all anodes are off; scanning continues.
- hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones  input  4 each  BCD digits from the counter chain.
- an  output  8  active-low anode selects; an[0] is the rightmost digit.
- seg  output  7  active-low cathodes {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point.

## Operation
- State:
  - slot counter cnt, 0 to REFRESH_DIV-1;
  - scan index idx, 0 to 7;
  - six 4-bit snapshot registers;
  - separator phase bit ph.
- cnt increments every cycle. When cnt==REFRESH_DIV-1, cnt goes to 0 and idx increments. idx wraps from 7 to 0.
- Snapshot loads all six inputs on the cycle where cnt==REFRESH_DIV-1 and idx==7. All other cycles hold.
- Slot map:
  - idx 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens, 4 = hour_ones, 5 = hour_tens.
  - idx 6 and 7 are unused: anodes stay off and seg=7'h7F.
- Decode (seg value per digit):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - 10 to 15 are non-BCD and display a dash: 0111111.
- Anode: an[idx]=0 only when display_en=1, cnt>=BLANK_CYCLES and idx<=5. Otherwise an=8'hFF.
- dp is 0 only when the anode is on, idx is 2 or 4, and ph==1. Otherwise dp=1.
- ph toggles on every cycle where sec_pulse=1.
- Reset values: cnt=0, idx=0, all snapshots 0, ph=0, an=8'hFF, seg=7'h7F, dp=1.

## Timing
- an, seg and dp are registered outputs. They reflect cnt, idx, snapshots and ph with exactly 1 cycle of latency.
- Frame length is 8×REFRESH_DIV cycles.
- An input change becomes visible at the start of the next frame after the snapshot cycle. Worst-case latency is 8×REFRESH_DIV+1 cycles.
- An input changing on the snapshot cycle itself is captured, because the snapshot samples the current value.
- sec_pulse coincident with the snapshot cycle: both take effect.
- Reset mid-frame clears everything asynchronously. an=8'hFF is visible immediately, with no clock required. After reset_n deasserts, scanning restarts from idx 0, cnt 0.
- display_en changes take effect on the next clk edge and do not disturb cnt or idx.

## Configuration
- LEADING_ZERO_BLANK_EN defined: in slot idx 5, when the hour_tens snapshot equals 0, the anode stays off (an=8'hFF, seg=7'h7F).
- LEADING_ZERO_BLANK_EN undefined: hour_tens=0 is displayed as "0" like any other digit.

## Test plan
- Reset behaviour: assert reset_n=0 mid-slot -> an=8'hFF, seg=7'h7F, dp=1 with no clock edge. After release, first anode enable is an=8'b11111110 at cycle BLANK_CYCLES+1.
- Scan order (REFRESH_DIV=4, BLANK_CYCLES=1, inputs 12:34:56, display_en=1, pulse ph to 1) -> slots 0 to 5 show:
  - an=FE, seg=0000010 (6);
  - an=FD, seg=0010010 (5);
  - an=FB, seg=0011001 (4), dp=0;
  - an=F7, seg=0110000 (3);
  - an=EF, seg=0100100 (2), dp=0;
  - an=DF, seg=1111001 (1);
  - then 8 cycles with an=FF, then repeat.
- Snapshot coherence: change inputs from 09:59:59 to 10:00:00 mid-frame -> the current frame shows only 09:59:59. The next frame shows only 10:00:00.
- Non-BCD input: sec_ones=4'hC -> slot 0 shows seg=0111111.
- Separator blink: three sec_pulse strobes -> dp sequence in slots 2 and 4 goes 0, 1, 0 per phase. dp=1 in all other slots.
- Leading-zero blank, with the macro defined: hour_tens=0 -> slot 5 shows an=FF. Without the macro: an=DF, seg=1000000.

Source files
------------

// File: rtl/clock_display_mux_if.sv
// ---------------------------------------------------------------------------
// clock_display_mux_if
//   Bundles the digit-counter inputs and the seven-segment outputs of the
//   clock display multiplexer.
//   master : the counter side / environment (drives digits, strobes, enable,
//            observes the display lines).
//   slave  : the display multiplexer itself.
//   Signals:
//     sec_pulse   one-cycle strobe per second (separator phase toggle)
//     display_en  global anode enable
//     hour_tens .. sec_ones  4-bit BCD digits
//     an [7:0]    active-low anodes, an[0] = rightmost digit
//     seg[6:0]    active-low cathodes {g,f,e,d,c,b,a}
//     dp          active-low decimal point
// ---------------------------------------------------------------------------
interface clock_display_mux_if;
  logic       sec_pulse;
  logic       display_en;
  logic [3:0] hour_tens;
  logic [3:0] hour_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output sec_pulse, display_en,
    output hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
    input  an, seg, dp
  );

  modport slave (
    input  sec_pulse, display_en,
    input  hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones,
    output an, seg, dp
  );
endinterface

// File: rtl/clock_display_mux.sv
// ---------------------------------------------------------------------------
// clock_display_mux
//   Time-multiplexed 8-digit common-anode seven-segment driver for an
//   HH.MM.SS clock. All six digits are snapshotted once per frame so a frame
//   never mixes pre- and post-carry values. Each digit slot starts with
//   BLANK_CYCLES of all-anodes-off to suppress ghosting. Separators (dp on
//   slots 2 and 4) blink with a phase bit toggled by sec_pulse.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      clock_display_mux_if.slave (digits, strobes, an/seg/dp)
//   Parameters:
//     REFRESH_DIV   clk cycles per digit slot (2 .. 2^20)
//     BLANK_CYCLES  blanked cycles at the start of each slot (< REFRESH_DIV)
//   Optional feature macro:
//     LEADING_ZERO_BLANK_EN  when defined, a zero hour_tens digit is blanked.
// ---------------------------------------------------------------------------
module clock_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  clock_display_mux_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0][3:0]  snap_q, snap_d;   // [0]=sec_ones .. [5]=hour_tens
  logic             ph_q, ph_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             slot_end_s;
  logic [3:0]       digit_s;
  logic             digit_valid_s;
  logic             an_on_s;

  // Slot/scan counters, frame snapshot and separator phase next-state.
  always_comb begin
    slot_end_s = (cnt_q == CNT_LAST);
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
    // Load on the last cycle of slot 7 so the new values open the next frame.
    if (slot_end_s && (idx_q == 3'd7)) begin
      snap_d = {bus.hour_tens, bus.hour_ones, bus.min_tens,
                bus.min_ones,  bus.sec_tens,  bus.sec_ones};
    end else begin
      snap_d = snap_q;
    end
    ph_d = ph_q ^ bus.sec_pulse;
  end

  // Digit selection and output next-state (registered one cycle later).
  always_comb begin
    case (idx_q)
      3'd0:    digit_s = snap_q[0];
      3'd1:    digit_s = snap_q[1];
      3'd2:    digit_s = snap_q[2];
      3'd3:    digit_s = snap_q[3];
      3'd4:    digit_s = snap_q[4];
      3'd5:    digit_s = snap_q[5];
      default: digit_s = 4'd0;
    endcase
    digit_valid_s = (idx_q <= 3'd5);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q == 3'd5) && (snap_q[5] == 4'd0)) begin
      digit_valid_s = 1'b0;
    end else begin
      digit_valid_s = (idx_q <= 3'd5);
    end
`endif
    an_on_s = bus.display_en && (cnt_q >= BLANK_LIM) && digit_valid_s;
    if (an_on_s) begin
      an_d = ~(8'h01 << idx_q);
    end else begin
      an_d = 8'hFF;
    end
    if (digit_valid_s) begin
      seg_d = seg_decode(digit_s);
    end else begin
      seg_d = 7'h7F;
    end
    dp_d = ~(an_on_s && ((idx_q == 3'd2) || (idx_q == 3'd4)) && ph_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      snap_q <= '0;
      ph_q   <= 1'b0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      ph_q   <= ph_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Self-checking bench for clock_display_mux: a frame-arithmetic reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_clock_display_mux;
  localparam int R  = 4;
  localparam int B  = 1;
  localparam int FR = 8 * R;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  clock_display_mux_if bus ();

  clock_display_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: cycles since reset release, frame digits, phase.
  int         k;
  int         ph;
  logic [3:0] snap [6];
  logic [3:0] cur  [6];   // [0]=sec_ones .. [5]=hour_tens
  logic [6:0] tab  [16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_digits();
    bus.sec_ones  = cur[0];
    bus.sec_tens  = cur[1];
    bus.min_ones  = cur[2];
    bus.min_tens  = cur[3];
    bus.hour_ones = cur[4];
    bus.hour_tens = cur[5];
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur[5] = 4'(h / 10); cur[4] = 4'(h % 10);
    cur[3] = 4'(m / 10); cur[2] = 4'(m % 10);
    cur[1] = 4'(s / 10); cur[0] = 4'(s % 10);
    drive_digits();
  endtask

  task automatic model_reset();
    k  = 0;
    ph = 0;
    for (int i = 0; i < 6; i++) snap[i] = 4'd0;
  endtask

  // One clock: predict from the spec's slot arithmetic, advance model, compare.
  task automatic step();
    int         pos, slot;
    logic       valid, on;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    pos   = k % R;
    slot  = (k / R) % 8;
    valid = (slot <= 5);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 5 && snap[5] == 4'd0) valid = 1'b0;
`endif
    on    = valid && bus.display_en && (pos >= B);
    e_an  = on ? ~(8'(1) << slot) : 8'hFF;
    e_seg = valid ? tab[snap[slot]] : 7'h7F;
    e_dp  = !(on && (slot == 2 || slot == 4) && ph == 1);
    @(posedge clk);
    if (k % FR == FR - 1) for (int i = 0; i < 6; i++) snap[i] = cur[i];
    if (bus.sec_pulse) ph = 1 - ph;
    k++;
    #1;
    chk("model_an",  bus.an, e_an);
    chk("model_seg", {1'b0, bus.seg}, {1'b0, e_seg});
    chk("model_dp",  {7'd0, bus.dp}, {7'd0, e_dp});
  endtask

  task automatic to_frame_start();
    while (k % FR != 0) step();
  endtask

  logic [7:0] lit_an  [6];
  logic [6:0] lit_seg [6];

  initial begin
    tab[0] = 7'b1000000; tab[1] = 7'b1111001; tab[2] = 7'b0100100;
    tab[3] = 7'b0110000; tab[4] = 7'b0011001; tab[5] = 7'b0010010;
    tab[6] = 7'b0000010; tab[7] = 7'b1111000; tab[8] = 7'b0000000;
    tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) tab[i] = 7'b0111111;
    lit_an[0] = 8'hFE; lit_seg[0] = 7'b0000010;
    lit_an[1] = 8'hFD; lit_seg[1] = 7'b0010010;
    lit_an[2] = 8'hFB; lit_seg[2] = 7'b0011001;
    lit_an[3] = 8'hF7; lit_seg[3] = 7'b0110000;
    lit_an[4] = 8'hEF; lit_seg[4] = 7'b0100100;
    lit_an[5] = 8'hDF; lit_seg[5] = 7'b1111001;

    set_time(12, 34, 56);
    bus.display_en = 1'b1;
    bus.sec_pulse  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_an",  bus.an, 8'hFF);
    chk("reset_seg", {1'b0, bus.seg}, 8'h7F);
    chk("reset_dp",  {7'd0, bus.dp}, 8'd1);
    reset_n = 1'b1;
    model_reset();

    // First anode enable two edges after release (BLANK_CYCLES+1).
    step();
    chk("first_blank_an", bus.an, 8'hFF);
    step();
    chk("first_on_an", bus.an, 8'hFE);

    // One pulse -> ph=1, then scan-order frame with 12:34:56.
    bus.sec_pulse = 1'b1; step(); bus.sec_pulse = 1'b0;
    to_frame_start();
    for (int p = 0; p < FR; p++) begin
      step();
      if (p % R == 2) begin
        if (p / R < 6) begin
          chk("scan_an",  bus.an, lit_an[p / R]);
          chk("scan_seg", {1'b0, bus.seg}, {1'b0, lit_seg[p / R]});
          chk("scan_dp",  {7'd0, bus.dp}, (p / R == 2 || p / R == 4) ? 8'd0 : 8'd1);
        end else begin
          chk("scan_unused_an", bus.an, 8'hFF);
        end
      end
    end

    // Snapshot coherence: change mid-frame, old digits stay for this frame.
    set_time(9, 59, 59);
    to_frame_start();
    for (int p = 0; p < FR; p++) step();
    for (int p = 0; p < FR; p++) begin
      if (p == 12) set_time(10, 0, 0);
      step();
      if (p == 18) chk("coherent_old_seg", {1'b0, bus.seg}, 8'b00010000);
    end
    for (int p = 0; p < FR; p++) begin
      step();
      if (p == 18) chk("coherent_new_seg", {1'b0, bus.seg}, 8'b01000000);
    end

    // Non-BCD digit shows a dash.
    cur[0] = 4'hC; drive_digits();
    to_frame_start();
    for (int p = 0; p < FR; p++) step();
    for (int p = 0; p < 3; p++) step();
    chk("nonbcd_seg", {1'b0, bus.seg}, 8'b00111111);
    chk("nonbcd_an",  bus.an, 8'hFE);

    // Separator blink: ph currently 1; three pulses -> 0,1,0.
    for (int n = 0; n < 3; n++) begin
      bus.sec_pulse = 1'b1; step(); bus.sec_pulse = 1'b0;
      to_frame_start();
      for (int p = 0; p <= 2 * R + 2; p++) step();
      chk("blink_dp", {7'd0, bus.dp}, (n % 2 == 0) ? 8'd1 : 8'd0);
    end

    // Leading zero on hour_tens.
    set_time(7, 5, 3);
    to_frame_start();
    for (int p = 0; p < FR; p++) step();
    for (int p = 0; p <= 5 * R + 2; p++) step();
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_an",  bus.an, 8'hFF);
    chk("lz_seg", {1'b0, bus.seg}, 8'h7F);
`else
    chk("lz_an",  bus.an, 8'hDF);
    chk("lz_seg", {1'b0, bus.seg}, 8'b01000000);
`endif

    // Randomized run with a mid-frame asynchronous reset.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        cur[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
        drive_digits();
      end
      bus.sec_pulse  = ($urandom_range(0, 5) == 0);
      bus.display_en = ($urandom_range(0, 4) != 0);
      if (c == 701) begin
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_an",  bus.an, 8'hFF);
        chk("midreset_seg", {1'b0, bus.seg}, 8'h7F);
        chk("midreset_dp",  {7'd0, bus.dp}, 8'd1);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
